// File: rtl/wb_regfile_commit_pkg.sv
// Shared constants and helpers for the writeback commit stage.
package wb_regfile_commit_pkg;

  localparam int GPR_IDX_W = 5;
  localparam int WORD_W    = 32;

  localparam logic [GPR_IDX_W-1:0] REG_ZERO   = 5'd0;
  localparam logic [3:0]           RF_WEN_ALL = 4'hF;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [GPR_IDX_W-1:0] gpr_idx_t;

  // $0 is hardwired, so only a nonzero destination is a real write.
  function automatic logic is_gpr_write(input gpr_idx_t idx);
    return idx != REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_regfile_commit_hilo_reg.sv
// HI/LO multiply/divide result registers with independent write enables.
// WB_BYPASS_EN selects same-cycle write-through on the read outputs.
module hilo_reg
  import wb_regfile_commit_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              w_hi,
  input  logic [WORD_W-1:0] hi_wdata,
  input  logic              w_lo,
  input  logic [WORD_W-1:0] lo_wdata,
  output logic [WORD_W-1:0] hi_data,
  output logic [WORD_W-1:0] lo_data
);

  word_t hi_q;
  word_t lo_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (w_hi) hi_q <= hi_wdata;
      if (w_lo) lo_q <= lo_wdata;
    end
  end

`ifdef WB_BYPASS_EN
  assign hi_data = w_hi ? hi_wdata : hi_q;
  assign lo_data = w_lo ? lo_wdata : lo_q;
`else
  assign hi_data = hi_q;
  assign lo_data = lo_q;
`endif

endmodule

// File: rtl/wb_regfile_commit.sv
// Writeback commit: GPR file, HI/LO, commit trace and retired-instruction counter.
// WB_BYPASS_EN enables same-cycle write-through on the GPR and HI/LO read ports.
module wb_regfile_commit
  import wb_regfile_commit_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WORD_W-1:0]    wb_write_data,
  input  logic [GPR_IDX_W-1:0] wb_write_reg,
  input  logic [WORD_W-1:0]    wb_addr,
  input  logic                 wb_stall,
  input  logic                 wb_w_hi,
  input  logic [WORD_W-1:0]    wb_hi_data,
  input  logic                 wb_w_lo,
  input  logic [WORD_W-1:0]    wb_lo_data,
  input  logic [GPR_IDX_W-1:0] rs_addr,
  output logic [WORD_W-1:0]    rs_data,
  input  logic [GPR_IDX_W-1:0] rt_addr,
  output logic [WORD_W-1:0]    rt_data,
  output logic [WORD_W-1:0]    hi_data,
  output logic [WORD_W-1:0]    lo_data,
  output logic [WORD_W-1:0]    debug_wb_pc,
  output logic [3:0]           debug_wb_rf_wen,
  output logic [GPR_IDX_W-1:0] debug_wb_rf_wnum,
  output logic [WORD_W-1:0]    debug_wb_rf_wdata,
  output logic [CNT_W-1:0]     perf_commit_cnt
);

  word_t gpr [NREG];
  logic  stall_q;
  logic  commit;
  logic  gpr_wr;
  word_t rs_stored;
  word_t rt_stored;

  assign gpr_wr = is_gpr_write(wb_write_reg);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else if (gpr_wr) begin
      gpr[wb_write_reg] <= wb_write_data;
    end
  end

  assign rs_stored = (rs_addr == REG_ZERO) ? '0 : gpr[rs_addr];
  assign rt_stored = (rt_addr == REG_ZERO) ? '0 : gpr[rt_addr];

`ifdef WB_BYPASS_EN
  assign rs_data = (gpr_wr && rs_addr == wb_write_reg) ? wb_write_data : rs_stored;
  assign rt_data = (gpr_wr && rt_addr == wb_write_reg) ? wb_write_data : rt_stored;
`else
  assign rs_data = rs_stored;
  assign rt_data = rt_stored;
`endif

  hilo_reg u_hilo (
    .clock    (clock),
    .reset    (reset),
    .w_hi     (wb_w_hi),
    .hi_wdata (wb_hi_data),
    .w_lo     (wb_w_lo),
    .lo_wdata (wb_lo_data),
    .hi_data  (hi_data),
    .lo_data  (lo_data)
  );

  // The WB register repeats its contents while stalled; only the first
  // cycle after an unstalled edge counts as a retirement.
  always_ff @(posedge clock) begin
    if (reset) stall_q <= 1'b1;
    else       stall_q <= wb_stall;
  end

  assign commit = !stall_q && (wb_addr != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_commit_cnt <= '0;
    end else if (commit) begin
      perf_commit_cnt <= perf_commit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign debug_wb_pc       = wb_addr;
  assign debug_wb_rf_wen   = (commit && gpr_wr) ? RF_WEN_ALL : 4'h0;
  assign debug_wb_rf_wnum  = wb_write_reg;
  assign debug_wb_rf_wdata = wb_write_data;

endmodule

// File: doc/wb_regfile_commit.md
# wb_regfile_commit

Consumer end of the writeback bundle: takes the registered MEM→WB outputs (GPR write, HI/LO writes, PC) and commits them into the 32×32 general register file and the HI/LO registers. Serves two combinational GPR read ports and HI/LO reads to decode/execute, with optional same-cycle write-through. Also drives the commit trace and a retired-instruction counter for the perf SoC.

## Interface
Parameters:
- `NREG`, 32, number of GPRs; index width is `log2(NREG)` = 5.
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clock` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `wb_write_data` in 32: GPR write data from writeback.
- `wb_write_reg` in 5: GPR destination; 0 means no GPR write.
- `wb_addr` in 32: PC of the committing instruction; 0 means bubble.
- `wb_stall` in 1: stall[4]; 1 means the writeback register held its value at the last edge.
- `wb_w_hi` in 1, `wb_hi_data` in 32: HI write enable and data.
- `wb_w_lo` in 1, `wb_lo_data` in 32: LO write enable and data.
- `rs_addr` in 5, `rs_data` out 32: read port A, combinational.
- `rt_addr` in 5, `rt_data` out 32: read port B, combinational.
- `hi_data` out 32, `lo_data` out 32: current HI/LO, combinational.
- `debug_wb_pc` out 32, `debug_wb_rf_wen` out 4, `debug_wb_rf_wnum` out 5, `debug_wb_rf_wdata` out 32: commit trace.
- `perf_commit_cnt` out CNT_W: retired-instruction count.

## Operation
- GPR write: at posedge, if `wb_write_reg != 0`, `gpr[wb_write_reg] <= wb_write_data`. Writes to $0 are discarded. Reads of $0 return 0 on both ports.
- Rewrites during stall: the writeback register holds, so the same write repeats. This is idempotent and allowed.
- HI/LO: `wb_w_hi` and `wb_w_lo` are independent. When both are 1 in the same cycle, both are written. A 0 enable holds the value.
- Commit qualifier: `stall_q` is `wb_stall` registered, with reset value 1. A commit is `!stall_q && wb_addr != 0`. This counts each instruction exactly once although the WB register holds during stalls.
- Counter: `perf_commit_cnt` increments by 1 on each commit. It wraps from all-ones to 0 with no saturation.
- Trace:
  - `debug_wb_pc = wb_addr`.
  - `debug_wb_rf_wen = {4{commit && wb_write_reg != 0}}`.
  - `debug_wb_rf_wnum = wb_write_reg`.
  - `debug_wb_rf_wdata = wb_write_data`.
  - These are combinational from the inputs, so the trace shows each write once.
- Reset mid-operation: the reset write takes priority over a pending write in the same cycle. All state clears.

## Timing
- Reset values:
  - All GPRs, HI, LO, and `perf_commit_cnt` are 0. `stall_q` is 1.
  - Trace outputs follow the inputs; their `wen` is 0 while `stall_q` is 1.
- Write latency: a value is visible from storage in the cycle after the edge that writes it.
- Read ports: zero-latency combinational. Same-cycle collision behaviour is set by the macro below.
- Counter is visible one cycle after the commit cycle.

## Configuration
- `WB_BYPASS_EN` defined: same-cycle write-through.
  - `rs_data`/`rt_data` return `wb_write_data` when the read address equals a nonzero `wb_write_reg`.
  - `hi_data`/`lo_data` return `wb_hi_data`/`wb_lo_data` while `wb_w_hi`/`wb_w_lo` is 1.
- `WB_BYPASS_EN` undefined: reads return stored values only. The pipeline must cover the one-cycle window by stalling or forwarding elsewhere.

## Structure
- Shared package holds:
  - `REG_ZERO` = 5'd0.
  - `GPR_IDX_W` = 5.
  - `WORD_W` = 32.
  - `RF_WEN_ALL` = 4'hF.
- Sub-module `hilo_reg` holds the HI/LO registers with independent enables and the bypass muxes.
- The GPR array, commit qualifier, counter and trace stay in the top module.

## Test plan
1. Reset, then read all 32 registers and HI/LO → all 0; counter 0; `debug_wb_rf_wen` = 0.
2. Write reg 5 = 0xDEADBEEF with `wb_addr` 0xBFC00000 and stall 0 → next cycle `rs_addr=5` reads 0xDEADBEEF; trace `wen`=0xF, `wnum`=5; counter goes 0→1.
3. Write reg 0 = 0x12345678 → `rs_addr=0` reads 0; trace `wen`=0; counter still increments.
4. Hold `wb_stall`=1 for 3 cycles with a valid instruction in WB → counter increments once in total; the reg value is unchanged and correct.
5. `wb_w_hi`=`wb_w_lo`=1 with HI=0x1, LO=0x2 → both updated next cycle. With `WB_BYPASS_EN`, same-cycle `hi_data`=0x1; without it, the old value.
6. Preload counter to 0xFFFFFFFF, then commit once → 0. Assert reset while a write to reg 7 is pending → reg 7 reads 0.
